// File: rtl/clk_monitor_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    MEASURE,
    LOCKED,
    LOST
  } state_t;

  // Unsigned-safe window test: avoids underflow of (exp_period - tol).
  function automatic logic in_tol(input int unsigned period,
                                  input int unsigned exp_period,
                                  input int unsigned tol);
    return ((period + tol) >= exp_period) && (period <= (exp_period + tol));
  endfunction

endpackage

// File: rtl/clk_monitor_sync.sv
// Synchronizer and registered rise/fall strobes for the divided clock.
// With CLK_MONITOR_GLITCH_FILTER_EN defined, a level must persist 2 cycles before it is accepted.
module clk_monitor_sync
#(
  parameter int SYNC_STAGES = 2
)
(
  input  logic clkin,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;

  assign s = sync_q[SYNC_STAGES-1];

  // The divider comes out of reset high, so the chain starts high too.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

`ifdef CLK_MONITOR_GLITCH_FILTER_EN
  logic s_q;
  logic stable;

  assign stable = (s == s_q);

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      s_q  <= 1'b1;
      s_d  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s_q  <= s;
      if (stable) begin
        s_d <= s;
      end
      rise <= stable & s & ~s_d;
      fall <= stable & ~s & s_d;
    end
  end
`else
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      s_d  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s_d  <= s;
      rise <= s & ~s_d;
      fall <= ~s & s_d;
    end
  end
`endif

endmodule

// File: rtl/clk_monitor.sv
// Divided-clock monitor: edge strobes, rise-to-rise period measurement, lock and loss detection.
// Optional glitch filtering in clk_monitor_sync is selected by CLK_MONITOR_GLITCH_FILTER_EN.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          PERIOD_W    = 8,
  parameter int unsigned EXP_PERIOD  = 4,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 16
)
(
  input  logic                clkin,
  input  logic                rst,
  input  logic                enable,
  input  logic                clk_div_in,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                lost
);

  //  state   | meaning
  //  IDLE    | monitor disabled, counters cleared, strobes suppressed
  //  ACQUIRE | waiting for the first rising edge to start the period counter
  //  MEASURE | counting consecutive in-tolerance periods toward lock
  //  LOCKED  | period within tolerance; any mismatch drops back to MEASURE
  //  LOST    | no edge for TIMEOUT cycles; next rise restarts measurement

  localparam int                MC_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [MC_W-1:0]     MC_LAST   = MC_W'(LOCK_COUNT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [MC_W-1:0]     match_cnt;
  logic [MC_W-1:0]     match_nxt;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] idle_cnt;
  logic                have_rise;
  logic                rise_s;
  logic                fall_s;
  logic                pv_evt;
  logic                match;
  logic                timeout;

  clk_monitor_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clkin (clkin),
    .rst   (rst),
    .d     (clk_div_in),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  assign pv_evt  = rise_s && have_rise;
  assign timeout = (idle_cnt == TIMEOUT_V);
  // A saturated counter means the real period is unknown, so it never matches.
  assign match   = pv_evt && in_tol(32'(cnt), EXP_PERIOD, TOL) && (cnt != CNT_MAX);

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    if (!enable) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          match_nxt = '0;
        end
        ACQUIRE: begin
          if (rise_s) begin
            state_nxt = MEASURE;
            match_nxt = '0;
          end else if (timeout) begin
            state_nxt = LOST;
          end
        end
        MEASURE: begin
          if (pv_evt) begin
            if (!match) begin
              match_nxt = '0;
            end else if (match_cnt == MC_LAST) begin
              state_nxt = LOCKED;
              match_nxt = '0;
            end else begin
              match_nxt = match_cnt + 1'b1;
            end
          end else if (!rise_s && timeout) begin
            state_nxt = LOST;
          end
        end
        LOCKED: begin
          if (pv_evt && !match) begin
            state_nxt = MEASURE;
            match_nxt = '0;
          end else if (!rise_s && timeout) begin
            state_nxt = LOST;
          end
        end
        LOST: begin
          if (rise_s) begin
            state_nxt = MEASURE;
            match_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          match_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      idle_cnt     <= '0;
      have_rise    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (!enable || (state == IDLE)) begin
      cnt          <= '0;
      idle_cnt     <= '0;
      have_rise    <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= pv_evt;
      if (rise_s) begin
        cnt       <= PERIOD_W'(1);
        have_rise <= 1'b1;
        if (have_rise) begin
          period <= cnt;
        end
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        // After a loss the next rise only restarts counting.
        if (state_nxt == LOST) begin
          have_rise <= 1'b0;
        end
      end
      if (rise_s || fall_s) begin
        idle_cnt <= '0;
      end else if (idle_cnt != CNT_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign rise_pulse = rise_s && (state != IDLE);
  assign fall_pulse = fall_s && (state != IDLE);
  assign locked     = (state == LOCKED);
  assign lost       = (state == LOST);

endmodule

// File: tb/tb_clk_monitor.sv
// Self-checking bench for clk_monitor: directed scenarios plus random segments against an event-time model.
module tb_clk_monitor;

  localparam int S     = 2;
  localparam int EXP   = 4;
  localparam int TOLV  = 0;
  localparam int LOCKN = 4;
  localparam int TMO   = 16;
  localparam int CMAX  = 255;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_MEAS = 2;
  localparam int M_LOCK = 3;
  localparam int M_LOST = 4;

  logic       clkin = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clk_div_in = 1'b1;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       lost;

  always #5 clkin = ~clkin;

  clk_monitor dut (
    .clkin        (clkin),
    .rst          (rst),
    .enable       (enable),
    .clk_div_in   (clk_div_in),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: sampled-level history, strobe times and a behavioural mode.
  logic hist[$];
  logic fl;
  int   k = 0;
  int   mst, mhave, last_rise, anchor, mcnt;
  logic r_prev, f_prev;
  int   e_rise, e_fall, e_period, e_pv, e_locked, e_lost;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < S + 2; i++) hist.push_back(1'b1);
    fl = 1'b1;
    mst = M_IDLE; mhave = 0; last_rise = 0; anchor = k; mcnt = 0;
    r_prev = 1'b0; f_prev = 1'b0;
    e_rise = 0; e_fall = 0; e_period = 0; e_pv = 0; e_locked = 0; e_lost = 0;
  endtask

  task automatic model_step();
    logic s, sq, r_new, f_new, tmo, mt;
    int   nst, p;
    k++;
    hist.push_front(clk_div_in);
    void'(hist.pop_back());
    s  = hist[S];
    sq = hist[S+1];
`ifdef CLK_MONITOR_GLITCH_FILTER_EN
    r_new = (s == sq) && s && !fl;
    f_new = (s == sq) && !s && fl;
    if (s == sq) fl = s;
`else
    r_new = s && !sq;
    f_new = !s && sq;
`endif
    nst = mst;
    e_pv = 0;
    if (!enable || mst == M_IDLE) begin
      nst = enable ? M_ACQ : M_IDLE;
      mhave = 0; anchor = k - 1; mcnt = 0;
    end else if (r_prev) begin
      mt = 1'b0;
      anchor = k - 1;
      if (mhave != 0) begin
        p = k - 1 - last_rise;
        if (p > CMAX) p = CMAX;
        e_period = p; e_pv = 1;
        mt = (p >= EXP - TOLV) && (p <= EXP + TOLV) && (p != CMAX);
      end
      last_rise = k - 1;
      mhave = 1;
      case (mst)
        M_ACQ, M_LOST: begin nst = M_MEAS; mcnt = 0; end
        M_MEAS: begin
          if (mt) begin
            mcnt++;
            if (mcnt == LOCKN) begin nst = M_LOCK; mcnt = 0; end
          end else mcnt = 0;
        end
        M_LOCK: if (!mt) begin nst = M_MEAS; mcnt = 0; end
        default: ;
      endcase
    end else begin
      // Quiet time: cycles elapsed since the last strobe cleared the idle counter.
      tmo = ((k - 2 - anchor) == TMO);
      if (f_prev) anchor = k - 1;
      if (tmo && mst != M_LOST) begin nst = M_LOST; mhave = 0; end
    end
    mst = nst;
    e_rise   = (r_new && mst != M_IDLE) ? 1 : 0;
    e_fall   = (f_new && mst != M_IDLE) ? 1 : 0;
    e_locked = (mst == M_LOCK) ? 1 : 0;
    e_lost   = (mst == M_LOST) ? 1 : 0;
    r_prev = r_new;
    f_prev = f_new;
  endtask

  task automatic check_all();
    check("rise_pulse", 32'(rise_pulse), e_rise);
    check("fall_pulse", 32'(fall_pulse), e_fall);
    check("period", 32'(period), e_period);
    check("period_valid", 32'(period_valid), e_pv);
    check("locked", 32'(locked), e_locked);
    check("lost", 32'(lost), e_lost);
    check("locked_lost_excl", 32'(locked && lost), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rise"}, 32'(rise_pulse), 0);
    check({tag, "_fall"}, 32'(fall_pulse), 0);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_pv"}, 32'(period_valid), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_lost"}, 32'(lost), 0);
  endtask

  task automatic tick(input logic lvl);
    clk_div_in = lvl;
    @(posedge clkin);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) tick((i % (hi + lo)) < hi);
  endtask

  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) tick(lvl);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clkin);
    #1;
    rst = 1'b1;
  endtask

  int   g_r, g_f, t_r, t_f, want_r, want_f;
  int   sel;
  logic lv;

  initial begin
    model_reset();
    #2;
    check_zero("reset");
    repeat (3) @(posedge clkin);
    #1;
    rst = 1'b1;

    // Lock on a 2/2 square wave
    enable = 1'b1;
    wave(2, 2, 40);
    check("t1_locked", 32'(locked), 1);
    check("t1_period", 32'(period), 4);

    // Loss on a stuck line, then recovery
    hold(1'b0, 30);
    check("t2_lost", 32'(lost), 1);
    check("t2_locked", 32'(locked), 0);
    wave(2, 2, 40);
    check("t2_relock", 32'(locked), 1);

    // Frequency change to period 6
    wave(3, 3, 30);
    check("t3_period", 32'(period), 6);
    check("t3_locked", 32'(locked), 0);

    // Asynchronous reset mid-MEASURE, then reacquire
    pulse_reset();
    wave(2, 2, 40);
    check("t5_relock", 32'(locked), 1);

    // Disable while locked: period holds, strobes suppressed
    enable = 1'b0;
    tick(1'b1);
    check("t4_locked", 32'(locked), 0);
    check("t4_period", 32'(period), 4);
    wave(1, 1, 8);
    enable = 1'b1;

    // Single-cycle glitch on a low line
    hold(1'b0, 25);
    g_r = 0; g_f = 0; t_r = -1; t_f = -1;
    for (int i = 0; i < 12; i++) begin
      tick(i == 0);
      if (rise_pulse) begin g_r++; t_r = i; end
      if (fall_pulse) begin g_f++; t_f = i; end
    end
`ifdef CLK_MONITOR_GLITCH_FILTER_EN
    want_r = 0; want_f = 0;
`else
    want_r = 1; want_f = 1;
`endif
    check("t6_rise_count", g_r, want_r);
    check("t6_fall_count", g_f, want_f);
    if (want_r == 1) check("t6_fall_after_rise", t_f - t_r, 1);

    // Random segments
    for (int seg = 0; seg < 30; seg++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: wave($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(8, 40));
        1: begin lv = 1'($urandom_range(0, 1)); hold(lv, $urandom_range(5, 25)); end
        2: begin
          enable = 1'b0;
          wave(2, 2, $urandom_range(1, 4));
          enable = 1'b1;
        end
        3: begin hold(1'b0, 3); tick(1'b1); hold(1'b0, 3); end
        4: wave(2, 2, 30);
        default: begin
          wave(2, 2, $urandom_range(5, 20));
          pulse_reset();
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
